// File: rtl/nanomips_pkg.sv
// nanomips_pkg
//    Shared definitions for the fetch sequencer slice: the sequencer state
//    encoding, the default program-counter and branch-target widths, the
//    width of the RUN cycle counter and a saturating increment helper.
//    No ports; imported by fetch_sequencer and branch_lut.

package nanomips_pkg;

   localparam int PC_W_DEFAULT  = 12;
   localparam int TGT_W_DEFAULT = 5;
   localparam int CYCLE_CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter increment that sticks at all-ones instead of rolling over, so a
   // very long program reports "at least this many cycles" rather than a
   // small wrapped number.
   function automatic logic [CYCLE_CNT_W-1:0] satInc(input logic [CYCLE_CNT_W-1:0] value);
      return (&value) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/branch_lut.sv
// branch_lut
//    Branch target lookup table: 2**TW entries of D bits each. Writes are
//    synchronous to clk; the read port is combinational, so a read of an
//    entry being written in the same cycle returns the previous contents.
//    Every entry is cleared by the asynchronous active-low reset.
//
// Ports
//    clk      in   clock, writes on rising edge
//    rst_n    in   asynchronous active-low reset, clears all entries
//    i_we     in   write enable
//    i_waddr  in   [TW-1:0] write index
//    i_wdata  in   [D-1:0]  write data
//    i_raddr  in   [TW-1:0] read index
//    o_rdata  out  [D-1:0]  read data (combinational)

module branch_lut
   import nanomips_pkg::*;
#(
   parameter int D  = PC_W_DEFAULT,
   parameter int TW = TGT_W_DEFAULT
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [TW-1:0] i_waddr,
   input  logic [D-1:0]  i_wdata,
   input  logic [TW-1:0] i_raddr,
   output logic [D-1:0]  o_rdata
);

   localparam int DEPTH = 1 << TW;

   logic [D-1:0] r_mem [DEPTH];

   // Storage array. Reset wipes every entry so a branch taken before the
   // table has been programmed lands on address 0 rather than stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Asynchronous read straight off the flops; because the write lands on
   // the clock edge, a same-cycle read sees the old entry.
   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//    Program-counter sequencer for a small in-order core. Waits in IDLE for
//    start, then in RUN steps the PC each cycle with priority
//    stall > halt > branch > increment, and parks in DONE on halt until the
//    next start. All outputs come straight from flops.
//
//    Build option FETCH_BRANCH_LUT_EN:
//       defined   - branch target is read from a 2**TW entry lookup table
//                   (branch_lut) indexed by target and loaded through lut_*.
//       undefined - branch target is PC plus the sign-extended target field,
//                   modulo 2**D; the lut_* ports are present but ignored.
//
// Ports
//    clk        in   clock, all state updates on rising edge
//    rst_n      in   asynchronous active-low reset
//    start      in   launch execution from address 0 (IDLE or DONE only)
//    stall      in   hold the PC this cycle
//    halt       in   halt instruction at the current PC
//    branch     in   taken branch/jump at the current PC
//    target     in   [TW-1:0] LUT index or signed PC offset
//    lut_we     in   LUT write enable
//    lut_addr   in   [TW-1:0] LUT write index
//    lut_data   in   [D-1:0]  LUT write data
//    prog_ctr   out  [D-1:0]  instruction memory address
//    busy       out  high while in RUN
//    done       out  high while in DONE
//    cycle_cnt  out  [15:0]   cycles spent in RUN, saturating

module fetch_sequencer
   import nanomips_pkg::*;
#(
   parameter int D  = PC_W_DEFAULT,
   parameter int TW = TGT_W_DEFAULT
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stall,
   input  logic                   halt,
   input  logic                   branch,
   input  logic [TW-1:0]          target,
   input  logic                   lut_we,
   input  logic [TW-1:0]          lut_addr,
   input  logic [D-1:0]           lut_data,
   output logic [D-1:0]           prog_ctr,
   output logic                   busy,
   output logic                   done,
   output logic [CYCLE_CNT_W-1:0] cycle_cnt
);

   state_t                 r_state;
   state_t                 w_nextState;
   logic [D-1:0]           r_pc;
   logic [D-1:0]           w_nextPc;
   logic [CYCLE_CNT_W-1:0] r_cnt;
   logic [CYCLE_CNT_W-1:0] w_nextCnt;
   logic                   r_busy;
   logic                   r_done;
   logic [D-1:0]           w_branchTgt;

`ifdef FETCH_BRANCH_LUT_EN
   logic [D-1:0] w_lutRdata;

   branch_lut #(
      .D  (D),
      .TW (TW)
   ) u_branchLut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (lut_we),
      .i_waddr (lut_addr),
      .i_wdata (lut_data),
      .i_raddr (target),
      .o_rdata (w_lutRdata)
   );

   assign w_branchTgt = w_lutRdata;
`else
   logic         w_unused_lut;
   logic [D-1:0] w_offset;

   // Without a table the LUT write port has nothing to drive; fold it into
   // one dummy bit so the ports stay but carry no logic.
   assign w_unused_lut = ^{lut_we, lut_addr, lut_data};

   // Size cast of a signed operand sign-extends, so negative offsets reach
   // backwards and the add wraps naturally modulo 2**D.
   assign w_offset    = D'($signed(target));
   assign w_branchTgt = r_pc + w_offset;
`endif

   // Next-state and next-value logic. Everything holds by default; IDLE
   // pins the PC at zero, RUN counts every cycle (stalls included) and
   // resolves the PC by priority, and start is only honoured outside RUN.
   always_comb begin
      w_nextState = r_state;
      w_nextPc    = r_pc;
      w_nextCnt   = r_cnt;
      case (r_state)
         IDLE: begin
            w_nextPc = '0;
            if (start) begin
               w_nextState = RUN;
               w_nextCnt   = '0;
            end
         end
         RUN: begin
            w_nextCnt = satInc(r_cnt);
            if (stall) begin
               w_nextPc = r_pc;
            end else if (halt) begin
               w_nextState = DONE;
            end else if (branch) begin
               w_nextPc = w_branchTgt;
            end else begin
               w_nextPc = r_pc + D'(1);
            end
         end
         DONE: begin
            if (start) begin
               w_nextState = RUN;
               w_nextPc    = '0;
               w_nextCnt   = '0;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextPc    = '0;
            w_nextCnt   = '0;
         end
      endcase
   end

   // State and output registers. busy/done are decoded from the next state
   // before the flop so they are true registered copies of the state and
   // can never be high together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_pc    <= w_nextPc;
         r_cnt   <= w_nextCnt;
         r_busy  <= (w_nextState == RUN);
         r_done  <= (w_nextState == DONE);
      end
   end

   assign prog_ctr  = r_pc;
   assign busy      = r_busy;
   assign done      = r_done;
   assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//    Directed self-checking bench for fetch_sequencer with default widths
//    (D=12, TW=5). Branch stimulus and expectations follow the
//    FETCH_BRANCH_LUT_EN build option.

module tb_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stall;
   logic        halt;
   logic        branch;
   logic [4:0]  target;
   logic        lut_we;
   logic [4:0]  lut_addr;
   logic [11:0] lut_data;
   logic [11:0] prog_ctr;
   logic        busy;
   logic        done;
   logic [15:0] cycle_cnt;

   int checkCount;
   int passCount;

`ifdef FETCH_BRANCH_LUT_EN
   localparam logic [4:0]  BR_TGT    = 5'd3;
   localparam logic [11:0] BR_EXP    = 12'h0A0;
   localparam logic [4:0]  WRAP_TGT  = 5'd1;
`else
   localparam logic [4:0]  BR_TGT    = 5'b11110;
   localparam logic [11:0] BR_EXP    = 12'd3;
   localparam logic [4:0]  WRAP_TGT  = 5'b11111;
`endif

   fetch_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stall     (stall),
      .halt      (halt),
      .branch    (branch),
      .target    (target),
      .lut_we    (lut_we),
      .lut_addr  (lut_addr),
      .lut_data  (lut_data),
      .prog_ctr  (prog_ctr),
      .busy      (busy),
      .done      (done),
      .cycle_cnt (cycle_cnt)
   );

   // Free-running 10 ns clock, first rising edge at 5 ns.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle's worth of inputs, let one rising edge pass, then
   // settle 1 ns so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic iStart, input logic iStall,
                                input logic iHalt, input logic iBranch,
                                input logic [4:0] iTarget, input logic iLutWe,
                                input logic [4:0] iLutAddr, input logic [11:0] iLutData);
      start    = iStart;
      stall    = iStall;
      halt     = iHalt;
      branch   = iBranch;
      target   = iTarget;
      lut_we   = iLutWe;
      lut_addr = iLutAddr;
      lut_data = iLutData;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 12'd0);
   endtask

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      stall      = 1'b0;
      halt       = 1'b0;
      branch     = 1'b0;
      target     = 5'd0;
      lut_we     = 1'b0;
      lut_addr   = 5'd0;
      lut_data   = 12'd0;

      #3;
      checkOutput("rst_pc",   32'(prog_ctr),  32'h0);
      checkOutput("rst_busy", 32'(busy),      32'h0);
      checkOutput("rst_done", 32'(done),      32'h0);
      checkOutput("rst_cnt",  32'(cycle_cnt), 32'h0);
      #9;
      rst_n = 1'b1;

      // IDLE without start, loading LUT[3]=0x0A0 meanwhile.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 12'h0A0);
      checkOutput("idle_busy", 32'(busy),     32'h0);
      checkOutput("idle_pc",   32'(prog_ctr), 32'h0);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 12'd0);
      checkOutput("start_busy", 32'(busy),      32'h1);
      checkOutput("start_done", 32'(done),      32'h0);
      checkOutput("start_pc",   32'(prog_ctr),  32'h0);
      checkOutput("start_cnt",  32'(cycle_cnt), 32'h0);

      for (int i = 1; i <= 5; i++) begin
         idleCycle();
         checkOutput($sformatf("seq_pc%0d", i),  32'(prog_ctr),  32'(i));
         checkOutput($sformatf("seq_cnt%0d", i), 32'(cycle_cnt), 32'(i));
      end
      checkOutput("seq_busy", 32'(busy), 32'h1);

      // Branch at PC 5 while LUT[3] is overwritten: old entry must win.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, BR_TGT, 1'b1, 5'd3, 12'h555);
      checkOutput("br_pc",  32'(prog_ctr),  32'(BR_EXP));
      checkOutput("br_cnt", 32'(cycle_cnt), 32'd6);

      // Asynchronous reset mid-cycle while running.
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_pc",   32'(prog_ctr),  32'h0);
      checkOutput("arst_busy", 32'(busy),      32'h0);
      checkOutput("arst_done", 32'(done),      32'h0);
      checkOutput("arst_cnt",  32'(cycle_cnt), 32'h0);
      #2;
      rst_n = 1'b1;
      idleCycle();
      checkOutput("arst_wait_busy", 32'(busy),     32'h0);
      checkOutput("arst_wait_pc",   32'(prog_ctr), 32'h0);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 12'd0);
      for (int i = 1; i <= 7; i++) begin
         idleCycle();
      end
      checkOutput("run2_pc7", 32'(prog_ctr), 32'd7);

      // Stall beats branch.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'b00100, 1'b0, 5'd0, 12'd0);
      checkOutput("stall_pc",  32'(prog_ctr),  32'd7);
      checkOutput("stall_cnt", 32'(cycle_cnt), 32'd8);

      idleCycle();
      checkOutput("post_stall_pc", 32'(prog_ctr), 32'd8);

      // start while running is ignored.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 12'd0);
      checkOutput("run_start_pc",  32'(prog_ctr),  32'd9);
      checkOutput("run_start_cnt", 32'(cycle_cnt), 32'd10);

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 12'd0);
      checkOutput("halt_done", 32'(done),      32'h1);
      checkOutput("halt_busy", 32'(busy),      32'h0);
      checkOutput("halt_pc",   32'(prog_ctr),  32'd9);
      checkOutput("halt_cnt",  32'(cycle_cnt), 32'd11);

      // DONE holds; LUT[1]=0xFFF is written here.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 12'hFFF);
      checkOutput("done_hold_done", 32'(done),      32'h1);
      checkOutput("done_hold_pc",   32'(prog_ctr),  32'd9);
      checkOutput("done_hold_cnt",  32'(cycle_cnt), 32'd11);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 12'd0);
      checkOutput("restart_pc",   32'(prog_ctr),  32'h0);
      checkOutput("restart_cnt",  32'(cycle_cnt), 32'h0);
      checkOutput("restart_busy", 32'(busy),      32'h1);
      checkOutput("restart_done", 32'(done),      32'h0);

      // Reach 0xFFF by branching, then increment must wrap to 0.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, WRAP_TGT, 1'b0, 5'd0, 12'd0);
      checkOutput("wrap_pre_pc", 32'(prog_ctr), 32'hFFF);
      idleCycle();
      checkOutput("wrap_pc",  32'(prog_ctr),  32'h0);
      checkOutput("wrap_cnt", 32'(cycle_cnt), 32'd2);

      // Long run: counter saturates, PC keeps wrapping (70000 mod 4096).
      for (int i = 0; i < 70000; i++) begin
         idleCycle();
      end
      checkOutput("sat_cnt",  32'(cycle_cnt), 32'hFFFF);
      checkOutput("sat_pc",   32'(prog_ctr),  32'd368);
      checkOutput("sat_busy", 32'(busy),      32'h1);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter D, default 12, program-counter width; instruction memory depth is 2**D.
REQ-002 SHALL have parameter TW, default 5, branch target field width.
REQ-003 SHALL have port clk, input, 1, single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, launches program execution from address 0.
REQ-006 SHALL have port stall, input, 1, holds the PC for this cycle.
REQ-007 SHALL have port halt, input, 1, decoded halt instruction at the current PC.
REQ-008 SHALL have port branch, input, 1, taken branch or jump at the current PC.
REQ-009 SHALL have port target, input, TW, branch LUT index or signed offset; see REQ-031.
REQ-010 SHALL have port lut_we, input, 1, branch LUT write enable.
REQ-011 SHALL have port lut_addr, input, TW, branch LUT write index.
REQ-012 SHALL have port lut_data, input, D, branch LUT write data.
REQ-013 SHALL have port prog_ctr, output, D, instruction memory address.
REQ-014 SHALL have port busy, output, 1, high while in RUN.
REQ-015 SHALL have port done, output, 1, high while in DONE.
REQ-016 SHALL have port cycle_cnt, output, 16, number of cycles spent in RUN.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-018 IDLE: prog_ctr SHALL hold 0; start=1 SHALL move to RUN next cycle with prog_ctr=0 and cycle_cnt=0.
REQ-019 RUN, each cycle, priority stall > halt > branch > increment:
  - stall: prog_ctr held.
  - halt: go to DONE; prog_ctr held at the halt address.
  - branch: prog_ctr = branch target next cycle.
  - otherwise: prog_ctr = prog_ctr+1.
REQ-020 Increment SHALL wrap from 2**D-1 to 0 without error.
REQ-021 cycle_cnt SHALL increment every RUN cycle, stalled cycles included, and saturate at 16'hFFFF.
REQ-022 start in RUN SHALL be ignored.
REQ-023 DONE: prog_ctr and cycle_cnt SHALL hold; start=1 SHALL re-enter RUN with prog_ctr=0 and cycle_cnt=0.
REQ-024 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both SHALL never be high together.
REQ-025 LUT writes SHALL be accepted in any state.
REQ-026 When a branch reads the LUT index being written in the same cycle, the read SHALL return the old entry.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, prog_ctr=0, cycle_cnt=0, busy=0, done=0, regardless of clk.
REQ-028 Reset in RUN SHALL abandon execution; after release, the block SHALL wait for start.
REQ-029 LUT contents SHALL be cleared to 0 by reset.

Configuration
REQ-030 Macro FETCH_BRANCH_LUT_EN defined: branch target = LUT[target]; the LUT has 2**TW entries of D bits.
REQ-031 Macro FETCH_BRANCH_LUT_EN undefined:
  - branch target = prog_ctr + sign-extended target, modulo 2**D.
  - No LUT storage; lut_we, lut_addr and lut_data stay as ports but are ignored.

Structure
REQ-032 Package nanomips_pkg SHALL hold the state enum typedef, the default values for D and TW, and the cycle_cnt width.
REQ-033 Sub-module branch_lut SHALL contain the LUT (sync write, async read); it is instantiated only under FETCH_BRANCH_LUT_EN.

Verification
REQ-034 Reset, then start, no branches, 4 cycles -> prog_ctr 0,1,2,3,4; busy=1; cycle_cnt=4.
REQ-035 LUT build, write LUT[3]=12'h0A0, branch with target=3 at PC 5 -> prog_ctr=12'h0A0 next cycle. Relative build, target=5'b11110 at PC 5 -> prog_ctr=3.
REQ-036 stall and branch together at PC 7 -> PC stays 7. Halt at PC 9 -> done=1, busy=0, PC held at 9.
REQ-037 PC at 12'hFFF, no branch -> PC 0 next cycle. Run 70000 cycles -> cycle_cnt=16'hFFFF.
REQ-038 rst_n low mid-RUN between clock edges -> outputs zero immediately. start in DONE -> PC 0, cycle_cnt 0, busy=1.
